motor_speed_ramp: RTL and testbench

Soft-start and soft-stop sequencer that sits directly upstream of the MG33 PWM top. It accepts a target speed-select and direction command. It then walks the PWM duty selector toward the target one step at a time, holding each step for a fixed dwell. A direction reversal always ramps to zero, waits out a dead time, and only then flips the direction line. This prevents current spikes and gearbox shock.

---
 rtl/motor_speed_ramp.sv | 144 ++++++++++++++
 tb/tb_motor_speed_ramp.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_speed_ramp.sv
// Soft-start/soft-stop sequencer feeding the PWM duty selector: walks Sel_o one step per dwell
// toward the target; a direction change ramps to zero, waits a dead time, then flips Dir_o.
module motor_speed_ramp #(
    parameter int SEL_W        = 3,
    parameter int DWELL_CYCLES = 50000,
    parameter int DWELL_W      = 16
) (
    input  logic             Clk_i,
    input  logic             Reset_i,
    input  logic [SEL_W-1:0] Target_sel_i,
    input  logic             Dir_cmd_i,
    input  logic             Cmd_valid_i,
    output logic             Cmd_ready_o,
    input  logic             Stop_i,
    output logic [SEL_W-1:0] Sel_o,
    output logic             Dir_o,
    output logic             Busy_o,
    output logic             Step_o
);

    typedef enum logic [1:0] {IDLE, RAMP_UP, RAMP_DOWN, FLIP} state_t;

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [SEL_W-1:0]   target_q, target_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               flip_q, flip_d;
    logic               dir_q, dir_d;
    logic               busy_q, busy_d;
    logic               step_q, step_d;

    logic               dwell_done;
    logic               accept;
    logic [SEL_W-1:0]   goal;
    logic [SEL_W-1:0]   sel_inc;
    logic [SEL_W-1:0]   sel_dec;

    assign dwell_done = (cnt_q == DWELL_LAST);
    assign accept     = Cmd_valid_i && (state_q == IDLE) && !Stop_i;
    // A reversal ramps down to zero first, whatever the latched target is.
    assign goal       = flip_q ? '0 : target_q;
    assign sel_inc    = sel_q + SEL_W'(1);
    assign sel_dec    = sel_q - SEL_W'(1);

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            target_q <= '0;
            sel_q    <= '0;
            flip_q   <= 1'b0;
            dir_q    <= 1'b1;
            busy_q   <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            sel_q    <= sel_d;
            flip_q   <= flip_d;
            dir_q    <= dir_d;
            busy_q   <= busy_d;
            step_q   <= step_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        sel_d    = sel_q;
        flip_d   = flip_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        if (Stop_i) begin
            state_d = IDLE;
            sel_d   = '0;
            cnt_d   = '0;
            flip_d  = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (accept) begin
                        target_d = Target_sel_i;
                        if (Dir_cmd_i != dir_q) begin
                            if (sel_q != '0) begin
                                state_d = RAMP_DOWN;
                                flip_d  = 1'b1;
                            end else begin
                                state_d = FLIP;
                            end
                        end else if (Target_sel_i > sel_q) begin
                            state_d = RAMP_UP;
                        end else if (Target_sel_i < sel_q) begin
                            state_d = RAMP_DOWN;
                        end
                    end
                end
                RAMP_UP: begin
                    cnt_d = cnt_q + DWELL_W'(1);
                    if (dwell_done) begin
                        cnt_d  = '0;
                        sel_d  = sel_inc;
                        step_d = 1'b1;
                        if (sel_inc == target_q) state_d = IDLE;
                    end
                end
                RAMP_DOWN: begin
                    cnt_d = cnt_q + DWELL_W'(1);
                    if (dwell_done) begin
                        cnt_d  = '0;
                        sel_d  = sel_dec;
                        step_d = 1'b1;
                        if (sel_dec == goal) state_d = flip_q ? FLIP : IDLE;
                    end
                end
                FLIP: begin
                    cnt_d = cnt_q + DWELL_W'(1);
                    if (dwell_done) begin
                        cnt_d   = '0;
                        dir_d   = ~dir_q;
                        flip_d  = 1'b0;
                        step_d  = 1'b1;
                        state_d = (target_q != '0) ? RAMP_UP : IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    always_comb begin
        Cmd_ready_o = (state_q == IDLE);
        Sel_o       = sel_q;
        Dir_o       = dir_q;
        Busy_o      = busy_q;
        Step_o      = step_q;
    end

endmodule

// File: tb/tb_motor_speed_ramp.sv
// Bench for motor_speed_ramp: two instances (dwell 4 and dwell 1); expected step events are
// queued when a command is issued and matched against each Step_o pulse.
module tb_motor_speed_ramp;

    typedef struct {
        int cyc;
        int sel;
        int dir;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] t1 = '0, t2 = '0;
    logic       d1 = 1'b0, d2 = 1'b0;
    logic       v1 = 1'b0, v2 = 1'b0;
    logic       st1 = 1'b0, st2 = 1'b0;
    logic [2:0] sel1, sel2;
    logic       rdy1, rdy2, dir1, dir2, busy1, busy2, step1, step2;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  q1[$];
    ev_t  q2[$];
    int   m_sel[2];
    int   m_dir[2];

    motor_speed_ramp #(.SEL_W(3), .DWELL_CYCLES(4), .DWELL_W(4)) u_dut1 (
        .Clk_i(clk), .Reset_i(rst), .Target_sel_i(t1), .Dir_cmd_i(d1),
        .Cmd_valid_i(v1), .Cmd_ready_o(rdy1), .Stop_i(st1), .Sel_o(sel1),
        .Dir_o(dir1), .Busy_o(busy1), .Step_o(step1)
    );

    motor_speed_ramp #(.SEL_W(3), .DWELL_CYCLES(1), .DWELL_W(2)) u_dut2 (
        .Clk_i(clk), .Reset_i(rst), .Target_sel_i(t2), .Dir_cmd_i(d2),
        .Cmd_valid_i(v2), .Cmd_ready_o(rdy2), .Stop_i(st2), .Sel_o(sel2),
        .Dir_o(dir2), .Busy_o(busy2), .Step_o(step2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (step1) begin
            if (q1.size() == 0) chk("dut1_spurious_step", 1, 0);
            else begin
                ev_t e;
                e = q1.pop_front();
                chk("dut1_step_cycle", cyc, e.cyc);
                chk("dut1_step_sel", 32'(sel1), e.sel);
                chk("dut1_step_dir", 32'(dir1), e.dir);
            end
        end
    end

    always @(negedge clk) begin
        if (step2) begin
            if (q2.size() == 0) chk("dut2_spurious_step", 1, 0);
            else begin
                ev_t e;
                e = q2.pop_front();
                chk("dut2_step_cycle", cyc, e.cyc);
                chk("dut2_step_sel", 32'(sel2), e.sel);
                chk("dut2_step_dir", 32'(dir2), e.dir);
            end
        end
    end

    task automatic push_ev(input int w, input int c, input int s, input int d);
        ev_t e;
        e.cyc = c;
        e.sel = s;
        e.dir = d;
        if (w == 0) q1.push_back(e);
        else        q2.push_back(e);
    endtask

    // Expected step sequence for a command accepted at edge n.
    task automatic plan(input int w, input int tg, input int d, input int n, input int dwell);
        int t;
        int s;
        int dr;
        t  = n;
        s  = m_sel[w];
        dr = m_dir[w];
        if (d != dr) begin
            while (s > 0) begin
                s--;
                t += dwell;
                push_ev(w, t, s, dr);
            end
            t += dwell;
            dr = d;
            push_ev(w, t, 0, dr);
            while (s < tg) begin
                s++;
                t += dwell;
                push_ev(w, t, s, dr);
            end
        end else if (tg > s) begin
            while (s < tg) begin
                s++;
                t += dwell;
                push_ev(w, t, s, dr);
            end
        end else begin
            while (s > tg) begin
                s--;
                t += dwell;
                push_ev(w, t, s, dr);
            end
        end
        m_sel[w] = s;
        m_dir[w] = dr;
    endtask

    task automatic send(input int w, input int tg, input int d);
        @(negedge clk);
        if (w == 0) begin
            t1 = 3'(tg); d1 = (d != 0); v1 = 1'b1;
        end else begin
            t2 = 3'(tg); d2 = (d != 0); v2 = 1'b1;
        end
        @(negedge clk);
        v1 = 1'b0;
        v2 = 1'b0;
        plan(w, tg, d, cyc, (w == 0) ? 4 : 1);
    endtask

    task automatic drain(input int w);
        int n;
        n = 0;
        while (((w == 0) ? q1.size() : q2.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("drain_timeout", 0, 1);
            q1.delete();
            q2.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_sel1(input int v);
        int n;
        n = 0;
        while (32'(sel1) != v && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("wait_sel_timeout", 0, 1);
    endtask

    task automatic reset_model();
        m_sel[0] = 0; m_sel[1] = 0;
        m_dir[0] = 1; m_dir[1] = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_model();
        repeat (3) @(negedge clk);
        chk("rst_sel", 32'(sel1), 0);
        chk("rst_dir", 32'(dir1), 1);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_step", 32'(step1), 0);
        chk("rst_ready", 32'(rdy1), 1);
        chk("rst_sel_dut2", 32'(sel2), 0);
        rst = 1'b0;
        @(negedge clk);

        // Ramp up from zero to 5
        send(0, 5, 1);
        chk("t1_busy_during", 32'(busy1), 1);
        chk("t1_ready_during", 32'(rdy1), 0);
        drain(0);
        chk("t1_sel_final", 32'(sel1), 5);
        chk("t1_busy_final", 32'(busy1), 0);
        chk("t1_ready_final", 32'(rdy1), 1);

        // Reversal: down to 0, dead time, flip, up to 2
        send(0, 2, 0);
        drain(0);
        chk("t2_sel_final", 32'(sel1), 2);
        chk("t2_dir_final", 32'(dir1), 0);
        chk("t2_busy_final", 32'(busy1), 0);

        // Same target, same direction: nothing happens
        send(0, 2, 0);
        chk("t3_busy", 32'(busy1), 0);
        chk("t3_ready", 32'(rdy1), 1);
        repeat (10) @(negedge clk);
        chk("t3_sel", 32'(sel1), 2);
        chk("t3_busy_later", 32'(busy1), 0);

        // Stop while ramping up at 3, with a command in the same cycle
        send(0, 6, 0);
        wait_sel1(3);
        @(negedge clk);
        st1 = 1'b1; v1 = 1'b1; t1 = 3'd7; d1 = 1'b1;
        q1.delete();
        m_sel[0] = 0;
        @(negedge clk);
        chk("t4_stop_sel", 32'(sel1), 0);
        chk("t4_stop_busy", 32'(busy1), 0);
        chk("t4_stop_dir", 32'(dir1), 0);
        chk("t4_stop_step", 32'(step1), 0);
        st1 = 1'b0; v1 = 1'b0;
        repeat (8) @(negedge clk);
        chk("t4_cmd_ignored_busy", 32'(busy1), 0);
        chk("t4_cmd_ignored_sel", 32'(sel1), 0);
        chk("t4_cmd_ignored_dir", 32'(dir1), 0);

        // Commands during RAMP_UP are ignored
        send(0, 4, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            t1 = 3'd7; d1 = 1'b1; v1 = 1'b1;
            chk("t5_ready_low", 32'(rdy1), 0);
            @(negedge clk);
            v1 = 1'b0;
        end
        drain(0);
        chk("t5_sel_after_ignored", 32'(sel1), 4);
        chk("t5_dir_after_ignored", 32'(dir1), 0);

        // Reset during FLIP
        send(0, 3, 1);
        wait_sel1(0);
        @(negedge clk);
        chk("t5_in_flip_busy", 32'(busy1), 1);
        rst = 1'b1;
        q1.delete();
        q2.delete();
        @(negedge clk);
        chk("t5_rst_sel", 32'(sel1), 0);
        chk("t5_rst_dir", 32'(dir1), 1);
        chk("t5_rst_busy", 32'(busy1), 0);
        chk("t5_rst_ready", 32'(rdy1), 1);
        rst = 1'b0;
        reset_model();
        repeat (8) @(negedge clk);
        chk("t5_post_rst_sel", 32'(sel1), 0);

        // Single-cycle dwell: one step per clock
        send(1, 7, 1);
        drain(1);
        chk("t6_sel_final", 32'(sel2), 7);
        chk("t6_busy_final", 32'(busy2), 0);
        chk("t6_ready_final", 32'(rdy2), 1);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
